// File: rtl/score_event_arbiter_if.sv
// Handshake bundle between the collision detectors / score tracker and the
// score event arbiter. The arbiter takes the slave side.
interface score_event_arbiter_if #(
    parameter int N_SRC  = 4,
    parameter int DROP_W = 8
);
    localparam int IDX_W = $clog2(N_SRC);

    logic              start;
    logic [N_SRC-1:0]  good_req;
    logic [N_SRC-1:0]  bad_req;
    logic              good_coll;
    logic              bad_coll;
    logic [IDX_W-1:0]  grant_idx;
    logic [1:0]        state;
    logic [N_SRC-1:0]  pending;
    logic [DROP_W-1:0] drop_cnt;

    modport master (
        output start, good_req, bad_req,
        input  good_coll, bad_coll, grant_idx, state, pending, drop_cnt
    );

    modport slave (
        input  start, good_req, bad_req,
        output good_coll, bad_coll, grant_idx, state, pending, drop_cnt
    );
endinterface

// File: rtl/score_event_arbiter.sv
// Collision event arbiter: round-robin good grants, bad-event priority, spaced
// single-cycle score pulses and the IDLE/PLAY/OVER game-session FSM.
module score_event_arbiter #(
    parameter int N_SRC  = 4,
    parameter int GAP    = 2,
    parameter int HOLD   = 8,
    parameter int DROP_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    score_event_arbiter_if.slave bus
);
    localparam int IDX_W    = $clog2(N_SRC);
    localparam int GAP_W    = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int HOLD_W   = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              good_q, good_d;
    logic              bad_q, bad_d;
    logic              bad_pend_q, bad_pend_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]  rr_q, rr_d;
    logic [IDX_W-1:0]  sel, rr_idx;
    logic [N_SRC-1:0]  pend_q, pend_d;
    logic [N_SRC-1:0]  grant_mask, drop_mask;
    logic [DROP_W-1:0] drop_q, drop_d, drop_inc;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              found, slot, issue_good;
    int                drop_sum;

    // Round-robin search starting at rr_q for the first pending good source.
    always_comb begin
        found  = 1'b0;
        sel    = '0;
        rr_idx = '0;
        for (int k = 0; k < N_SRC; k++) begin
            rr_idx = IDX_W'((int'(rr_q) + k) % N_SRC);
            if (!found && pend_q[rr_idx]) begin
                found = 1'b1;
                sel   = rr_idx;
            end
        end
    end

    assign slot       = (state_q == PLAY) && (gap_q == '0);
    assign issue_good = slot && !bad_pend_q && found;
    assign grant_mask = issue_good ? (N_SRC'(1) << sel) : '0;
    assign drop_mask  = bus.good_req & pend_q & ~grant_mask;

    // Every overwritten pending slot is one lost event; the count saturates.
    always_comb begin
        drop_sum = int'(drop_q);
        for (int k = 0; k < N_SRC; k++) begin
            drop_sum = drop_sum + int'(drop_mask[k]);
        end
        drop_inc = (drop_sum > DROP_MAX) ? '1 : DROP_W'(drop_sum);
    end

    always_comb begin
        state_d    = state_q;
        good_d     = 1'b0;
        bad_d      = 1'b0;
        bad_pend_d = bad_pend_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        pend_d     = pend_q;
        drop_d     = drop_q;
        gap_d      = (gap_q != '0) ? gap_q - GAP_W'(1) : gap_q;
        hold_d     = hold_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = PLAY;
                    drop_d  = '0;
                end
            end
            PLAY: begin
                // A bad event ends the session and discards this cycle's requests.
                if (slot && bad_pend_q) begin
                    bad_d      = 1'b1;
                    pend_d     = '0;
                    bad_pend_d = 1'b0;
                    hold_d     = HOLD_W'(HOLD - 1);
                    state_d    = OVER;
                end else begin
                    pend_d     = (pend_q & ~grant_mask) | bus.good_req;
                    bad_pend_d = bad_pend_q | (|bus.bad_req);
                    drop_d     = drop_inc;
                    if (issue_good) begin
                        good_d  = 1'b1;
                        grant_d = sel;
                        rr_d    = IDX_W'((int'(sel) + 1) % N_SRC);
                        gap_d   = GAP_W'(GAP);
                    end
                end
            end
            OVER: begin
                if (hold_q == '0) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            good_q     <= 1'b0;
            bad_q      <= 1'b0;
            bad_pend_q <= 1'b0;
            grant_q    <= '0;
            rr_q       <= '0;
            pend_q     <= '0;
            drop_q     <= '0;
            gap_q      <= '0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
            bad_pend_q <= bad_pend_d;
            grant_q    <= grant_d;
            rr_q       <= rr_d;
            pend_q     <= pend_d;
            drop_q     <= drop_d;
            gap_q      <= gap_d;
            hold_q     <= hold_d;
        end
    end

    assign bus.good_coll = good_q;
    assign bus.bad_coll  = bad_q;
    assign bus.grant_idx = grant_q;
    assign bus.state     = state_q;
    assign bus.pending   = pend_q;
    assign bus.drop_cnt  = drop_q;
endmodule

// File: tb/tb_score_event_arbiter.sv
// Self-checking bench for score_event_arbiter: directed scenarios followed by
// random traffic, all compared against an event-level reference model.
module tb_score_event_arbiter;
    localparam int N_SRC    = 4;
    localparam int GAP      = 2;
    localparam int HOLD     = 8;
    localparam int DROP_W   = 8;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_bad = 0;

    score_event_arbiter_if #(.N_SRC(N_SRC), .DROP_W(DROP_W)) bus ();

    score_event_arbiter #(
        .N_SRC(N_SRC), .GAP(GAP), .HOLD(HOLD), .DROP_W(DROP_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: session mode, pending events, cycle stamps of the
    // last good pulse and of the planned return to IDLE.
    int m_mode, m_rr, m_grant, m_drop, cyc, m_last_good, m_over_exit;
    bit m_pend[N_SRC];
    bit m_badf, m_good, m_badp;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_bad++;
            $display("[TB] FAIL %s at cycle %0d: got=%0d want=%0d", tag, cyc, got, want);
        end
    endtask

    function automatic logic [N_SRC-1:0] packPend();
        logic [N_SRC-1:0] v;
        v = '0;
        for (int i = 0; i < N_SRC; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic modelReset();
        m_mode = 0; m_rr = 0; m_grant = 0; m_drop = 0;
        m_badf = 0; m_good = 0; m_badp = 0;
        m_last_good = cyc - 1000;
        m_over_exit = 0;
        for (int i = 0; i < N_SRC; i++) m_pend[i] = 0;
    endtask

    task automatic modelStep(input logic st, input logic [N_SRC-1:0] g, input logic [N_SRC-1:0] b);
        int gi;
        bit slot;
        cyc++;
        m_good = 0;
        m_badp = 0;
        case (m_mode)
            0: if (st) begin m_mode = 1; m_drop = 0; end
            1: begin
                slot = (cyc - m_last_good) > GAP;
                if (slot && m_badf) begin
                    m_badp = 1;
                    m_badf = 0;
                    for (int i = 0; i < N_SRC; i++) m_pend[i] = 0;
                    m_mode = 2;
                    m_over_exit = cyc + HOLD;
                end else begin
                    gi = -1;
                    if (slot) begin
                        for (int k = 0; k < N_SRC; k++) begin
                            if (gi < 0 && m_pend[(m_rr + k) % N_SRC]) gi = (m_rr + k) % N_SRC;
                        end
                    end
                    if (gi >= 0) begin
                        m_good = 1;
                        m_grant = gi;
                        m_rr = (gi + 1) % N_SRC;
                        m_last_good = cyc;
                        m_pend[gi] = 0;
                    end
                    for (int i = 0; i < N_SRC; i++) begin
                        if (g[i]) begin
                            if (m_pend[i] && i != gi) m_drop = (m_drop < DROP_MAX) ? m_drop + 1 : DROP_MAX;
                            m_pend[i] = 1;
                        end
                    end
                    if (b != '0) m_badf = 1;
                end
            end
            default: if (cyc == m_over_exit) m_mode = 0;
        endcase
    endtask

    task automatic compareAll();
        checkOutput("state", 32'(bus.state), 32'(m_mode));
        checkOutput("good_coll", 32'(bus.good_coll), 32'(m_good));
        checkOutput("bad_coll", 32'(bus.bad_coll), 32'(m_badp));
        checkOutput("grant_idx", 32'(bus.grant_idx), 32'(m_grant));
        checkOutput("pending", 32'(bus.pending), 32'(packPend()));
        checkOutput("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
    endtask

    task automatic applyStimulus(input logic st, input logic [N_SRC-1:0] g, input logic [N_SRC-1:0] b);
        @(negedge clk);
        bus.start    = st;
        bus.good_req = g;
        bus.bad_req  = b;
        @(posedge clk);
        modelStep(st, g, b);
        #1;
        compareAll();
    endtask

    task automatic doReset();
        @(negedge clk);
        bus.start    = 1'b0;
        bus.good_req = '0;
        bus.bad_req  = '0;
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_state", 32'(bus.state), 0);
        checkOutput("rst_good", 32'(bus.good_coll), 0);
        checkOutput("rst_bad", 32'(bus.bad_coll), 0);
        checkOutput("rst_grant", 32'(bus.grant_idx), 0);
        checkOutput("rst_pending", 32'(bus.pending), 0);
        checkOutput("rst_drop", 32'(bus.drop_cnt), 0);
        modelReset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0);
    endtask

    initial begin
        int n_pulse, last_rise, n_src1, n_hold;
        logic [N_SRC-1:0] g, b;
        logic st;
        cyc = 0;
        bus.start = 1'b0;
        bus.good_req = '0;
        bus.bad_req = '0;
        modelReset();
        doReset();

        applyStimulus(1'b1, '0, '0);
        checkOutput("t1_play", 32'(bus.state), 1);
        applyStimulus(1'b0, 4'b0001, '0);
        checkOutput("t1_early", 32'(bus.good_coll), 0);
        applyStimulus(1'b0, '0, '0);
        checkOutput("t1_pulse", 32'(bus.good_coll), 1);
        checkOutput("t1_idx", 32'(bus.grant_idx), 0);

        // All four sources at once after a fresh reset: grants 0..3, three cycles apart.
        doReset();
        applyStimulus(1'b1, '0, '0);
        applyStimulus(1'b0, 4'b1111, '0);
        n_pulse = 0;
        last_rise = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, '0, '0);
            if (bus.good_coll) begin
                checkOutput("t2_idx", 32'(bus.grant_idx), 32'(n_pulse));
                if (n_pulse > 0) checkOutput("t2_spacing", 32'(cyc - last_rise), 3);
                last_rise = cyc;
                n_pulse++;
            end
        end
        checkOutput("t2_count", 32'(n_pulse), 4);

        applyStimulus(1'b0, 4'b0001, '0);
        n_src1 = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, (i < 3) ? 4'b0010 : 4'b0000, '0);
            if (bus.good_coll && bus.grant_idx == 2'd1) n_src1++;
        end
        checkOutput("t3_src1_pulses", 32'(n_src1), 1);
        checkOutput("t3_drop", 32'(bus.drop_cnt), 2);

        applyStimulus(1'b0, 4'b0001, '0);
        applyStimulus(1'b0, 4'b0110, '0);
        applyStimulus(1'b0, '0, 4'b1000);
        checkOutput("t4_pending", 32'(bus.pending), 32'(4'b0110));
        applyStimulus(1'b0, '0, '0);
        checkOutput("t4_wait_gap", 32'(bus.bad_coll), 0);
        applyStimulus(1'b0, '0, '0);
        checkOutput("t4_bad", 32'(bus.bad_coll), 1);
        checkOutput("t4_cleared", 32'(bus.pending), 0);
        checkOutput("t4_over", 32'(bus.state), 2);

        // While OVER, random requests and start must all be ignored.
        n_hold = 0;
        while (bus.state != 2'd0 && n_hold < 20) begin
            st = 1'($urandom_range(0, 1));
            g  = N_SRC'($urandom_range(0, 15));
            b  = N_SRC'($urandom_range(0, 15));
            applyStimulus(st, g, b);
            n_hold++;
        end
        checkOutput("t4_hold", 32'(n_hold), 8);

        for (int i = 0; i < 6; i++) begin
            g = N_SRC'($urandom_range(0, 15));
            b = N_SRC'($urandom_range(0, 15));
            applyStimulus(1'b0, g, b);
            checkOutput("t5_idle_pulse", 32'(bus.good_coll | bus.bad_coll), 0);
            checkOutput("t5_idle_pending", 32'(bus.pending), 0);
        end
        checkOutput("t5_drop_kept", 32'(bus.drop_cnt), 2);

        applyStimulus(1'b1, '0, '0);
        applyStimulus(1'b0, 4'b0001, '0);
        applyStimulus(1'b0, 4'b0100, '0);
        checkOutput("t6_pending_set", 32'(bus.pending), 32'(4'b0100));
        doReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, '0, '0);
            checkOutput("t6_no_pulse", 32'(bus.good_coll | bus.bad_coll), 0);
        end

        for (int i = 0; i < 1500; i++) begin
            st = ($urandom_range(0, 7) == 0);
            g  = N_SRC'($urandom_range(0, 15) & $urandom_range(0, 15));
            b  = '0;
            if ($urandom_range(0, 39) == 0) b = N_SRC'(1) << $urandom_range(0, N_SRC - 1);
            applyStimulus(st, g, b);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
